uncache_axi_bridge: RTL
=======================

# uncache_axi_bridge

Single-outstanding AXI4 master that carries the 32-bit uncached MMIO accesses produced by the uncache splitter (UART, SPI ctrl, SPI flash, CLINT window) onto the uncached AXI4 port. It sits directly downstream of the splitter's `arb_*` request interface. Each request is one single-beat AXI4 transaction. The bridge returns one-cycle `finish` pulses, which the splitter uses to advance from the upper word to the lower word.

## Interface
Parameters:
- `AXI_ID`, 4'd0: fixed value driven on AWID/ARID.
- `ADDR_W`, 64: request and AXI address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `uc_addr` input 64: byte address; bit 2 selects the 32-bit lane of the 64-bit bus.
- `uc_data` input 64: write data; only bits [31:0] are meaningful.
- `uc_mask` input 8: byte mask; bits [3:0] are used.
- `uc_we` input 1: write request level, held by the requester until `uc_finish`.
- `uc_re` input 1: read request level, held by the requester until `uc_finish`.
- `uc_rdata` output 64: read result, zero-extended 32-bit word.
- `uc_finish` output 1: one-cycle completion pulse.
- `uc_err` output 1: pulses together with `uc_finish` when the response is not OKAY.
- `axi_aw_valid` output 1, `axi_aw_ready` input 1, `axi_aw_addr` output 64, `axi_aw_id` output 4, `axi_aw_len` output 8, `axi_aw_size` output 3, `axi_aw_burst` output 2: AXI4 write-address channel.
- `axi_w_valid` output 1, `axi_w_ready` input 1, `axi_w_data` output 64, `axi_w_strb` output 8, `axi_w_last` output 1: AXI4 write-data channel.
- `axi_b_valid` input 1, `axi_b_ready` output 1, `axi_b_resp` input 2, `axi_b_id` input 4: AXI4 write-response channel.
- `axi_ar_valid` output 1, `axi_ar_ready` input 1, `axi_ar_addr` output 64, `axi_ar_id` output 4, `axi_ar_len` output 8, `axi_ar_size` output 3, `axi_ar_burst` output 2: AXI4 read-address channel.
- `axi_r_valid` input 1, `axi_r_ready` output 1, `axi_r_data` input 64, `axi_r_resp` input 2, `axi_r_last` input 1, `axi_r_id` input 4: AXI4 read-data channel.

## Operation
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - `uc_we`=1 latches addr/data/mask and goes to WADDR.
  - Otherwise `uc_re`=1 latches and goes to RADDR.
  - Both asserted: write wins.
- WADDR:
  - `axi_aw_valid` and `axi_w_valid` are asserted together.
  - Each valid drops independently after its own handshake; two sticky flags track acceptance.
  - Go to WRESP once both flags are set, including the cycle in which the second handshake occurs.
- WRESP: `axi_b_ready`=1. On `axi_b_valid`, capture `resp != 2'b00` into the error flag and go to DONE.
- RADDR: `axi_ar_valid`=1. On `axi_ar_ready`, go to RDATA.
- RDATA:
  - `axi_r_ready`=1.
  - On `axi_r_valid`, `uc_rdata` is loaded from the lane selected by addr[2]: addr[2]=1 gives {32'h0, data[63:32]}; addr[2]=0 gives {32'h0, data[31:0]}.
  - Capture the error flag from `axi_r_resp`, then go to DONE.
- DONE: `uc_finish`=1 for exactly one cycle, `uc_err`=error flag; then return to IDLE.
- Address and control fields:
  - AXI addresses are {latched_addr[63:2], 2'b00}.
  - len=0, size=3'b010, burst=INCR (2'b01), last=1.
  - IDs are `AXI_ID`; incoming b/r IDs are ignored.
- Write lanes:
  - addr[2]=1: w_data={data[31:0], 32'h0}, w_strb={mask[3:0], 4'h0}.
  - addr[2]=0: w_data={32'h0, data[31:0]}, w_strb={4'h0, mask[3:0]}.
- All AXI outputs are registered. Address, data and strobe are held stable while the corresponding valid is high.
- `uc_rdata` holds its last value until the next read completes.

## Timing
- Reset (`rst`=1 at an edge): state=IDLE; all valids, readies, `uc_finish` and `uc_err` = 0; `uc_rdata`=0.
- Reset mid-transaction abandons the transaction; the AXI slave shares `rst`.
- Request is sampled in IDLE at edge 0; valid rises after edge 0 (cycle 1).
- Minimum read latency, ready slave: AR handshake cycle 1, R handshake cycle 2, `uc_finish` cycle 3.
- Minimum write latency: AW+W handshake cycle 1, B cycle 2, `uc_finish` cycle 3.
- Back-pressure stretches the relevant state indefinitely; no timeout.
- No new request is sampled until the cycle after DONE. The requester must present its next request (e.g. the lower word) no earlier than the `uc_finish` cycle.
- AW and W may be accepted in any order or in the same cycle.

## Test plan
- Read at 0x1000_0004, arready=1, slave returns r_data=0xAABBCCDD_11223344 -> cycle 3: `uc_finish`=1, `uc_rdata`=0x00000000_AABBCCDD, `uc_err`=0.
- Write at 0x1000_0000, data=0x..._DEADBEEF, mask=0x0F -> w_data=0x00000000_DEADBEEF, w_strb=0x0F, aw_addr=0x1000_0000; `uc_finish` after B.
- Write at 0x0200_4004, awready delayed 3 cycles, wready immediate -> w_valid drops after 1 cycle, aw_valid held 4 cycles, exactly one `uc_finish`.
- `uc_we` and `uc_re` both asserted -> write transaction issued, ar_valid stays 0.
- Read where slave returns r_resp=2'b10 -> `uc_finish` and `uc_err` both pulse for one cycle.
- `rst` asserted in RDATA -> next cycle: IDLE, r_ready=0, `uc_rdata`=0, no `uc_finish`.

Source files
------------

// File: rtl/uncache_axi_bridge.sv
// Single-outstanding AXI4 master for 32-bit uncached MMIO accesses.
// Every request becomes one single-beat AXI4 transaction. Completion is
// reported with a one-cycle uc_finish pulse, with uc_err marking a non-OKAY
// response.
module uncache_axi_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // Requester side
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [63:0]       uc_data,
  input  logic [7:0]        uc_mask,
  input  logic              uc_we,
  input  logic              uc_re,
  output logic [63:0]       uc_rdata,
  output logic              uc_finish,
  output logic              uc_err,
  // AXI4 write address
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic [3:0]        axi_aw_id,
  output logic [7:0]        axi_aw_len,
  output logic [2:0]        axi_aw_size,
  output logic [1:0]        axi_aw_burst,
  // AXI4 write data
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  output logic [63:0]       axi_w_data,
  output logic [7:0]        axi_w_strb,
  output logic              axi_w_last,
  // AXI4 write response
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  input  logic [1:0]        axi_b_resp,
  input  logic [3:0]        axi_b_id,
  // AXI4 read address
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [3:0]        axi_ar_id,
  output logic [7:0]        axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [1:0]        axi_ar_burst,
  // AXI4 read data
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [63:0]       axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last,
  input  logic [3:0]        axi_r_id
);

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata,
    StDone
  } state_e;

  state_e r_state;
  logic   r_aw_done;  // AW accepted in the current write
  logic   r_w_done;   // W accepted in the current write
  logic   r_lane;     // addr[2] of the current read: selects upper word

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_unused_bits;

  // Fixed single-beat, 32-bit, INCR transaction attributes
  assign axi_aw_id    = AXI_ID;
  assign axi_aw_len   = 8'd0;
  assign axi_aw_size  = 3'b010;
  assign axi_aw_burst = 2'b01;
  assign axi_w_last   = 1'b1;
  assign axi_ar_id    = AXI_ID;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = 3'b010;
  assign axi_ar_burst = 2'b01;

  // Acceptance including a handshake happening this cycle
  assign w_aw_hs = axi_aw_valid & axi_aw_ready;
  assign w_w_hs  = axi_w_valid & axi_w_ready;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  // Inputs that carry no meaning for 32-bit single-beat accesses
  assign w_unused_bits = ^{uc_addr[1:0], uc_data[63:32], uc_mask[7:4],
                           axi_b_id, axi_r_id, axi_r_last};

  // Transaction FSM; every AXI and requester output is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_lane       <= 1'b0;
      uc_rdata     <= 64'h0;
      uc_finish    <= 1'b0;
      uc_err       <= 1'b0;
      axi_aw_valid <= 1'b0;
      axi_aw_addr  <= '0;
      axi_w_valid  <= 1'b0;
      axi_w_data   <= 64'h0;
      axi_w_strb   <= 8'h0;
      axi_b_ready  <= 1'b0;
      axi_ar_valid <= 1'b0;
      axi_ar_addr  <= '0;
      axi_r_ready  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Write wins when both request levels are present
          if (uc_we) begin
            axi_aw_addr  <= {uc_addr[ADDR_W-1:2], 2'b00};
            axi_aw_valid <= 1'b1;
            axi_w_valid  <= 1'b1;
            if (uc_addr[2]) begin
              axi_w_data <= {uc_data[31:0], 32'h0};
              axi_w_strb <= {uc_mask[3:0], 4'h0};
            end else begin
              axi_w_data <= {32'h0, uc_data[31:0]};
              axi_w_strb <= {4'h0, uc_mask[3:0]};
            end
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= StWaddr;
          end else if (uc_re) begin
            axi_ar_addr  <= {uc_addr[ADDR_W-1:2], 2'b00};
            axi_ar_valid <= 1'b1;
            r_lane       <= uc_addr[2];
            r_state      <= StRaddr;
          end
        end
        StWaddr: begin
          if (w_aw_hs) axi_aw_valid <= 1'b0;
          if (w_w_hs)  axi_w_valid  <= 1'b0;
          r_aw_done <= w_aw_ok;
          r_w_done  <= w_w_ok;
          if (w_aw_ok && w_w_ok) begin
            axi_b_ready <= 1'b1;
            r_state     <= StWresp;
          end
        end
        StWresp: begin
          if (axi_b_valid) begin
            axi_b_ready <= 1'b0;
            uc_err      <= (axi_b_resp != 2'b00);
            uc_finish   <= 1'b1;
            r_state     <= StDone;
          end
        end
        StRaddr: begin
          if (axi_ar_ready) begin
            axi_ar_valid <= 1'b0;
            axi_r_ready  <= 1'b1;
            r_state      <= StRdata;
          end
        end
        StRdata: begin
          if (axi_r_valid) begin
            axi_r_ready <= 1'b0;
            uc_rdata    <= r_lane ? {32'h0, axi_r_data[63:32]} : {32'h0, axi_r_data[31:0]};
            uc_err      <= (axi_r_resp != 2'b00);
            uc_finish   <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          uc_finish <= 1'b0;
          uc_err    <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
